lane_sensor_conditioner: RTL and testbench

LANE_SENSOR_CONDITIONER -- requirements
Module: lane_sensor_conditioner

---
 rtl/lane_sensor_conditioner.sv | 152 +++++++++++++++
 tb/tb_lane_sensor_conditioner.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/lane_sensor_conditioner.sv
// rtl/lane_sensor_conditioner.sv - four-lane stop-line / congestion loop conditioner
//
// Purpose: synchronizes and debounces raw stop-line (s1) and congestion (s5)
// loop inputs for lanes NS1, NS2, EW1, EW2, qualifies congestion, counts
// vehicles per lane and flags inconsistent loop combinations.
//
// Ports:
//   clk            system clock, rising edge
//   rst            synchronous active-high reset
//   raw_s1[3:0]    raw stop-line loops (async), bit0 NS1 .. bit3 EW2
//   raw_s5[3:0]    raw congestion loops (async), same lane order
//   clr            synchronous clear of vehicle counts and fault flags
//   S1_<lane>      debounced presence level
//   S5_<lane>      qualified congestion level
//   veh_count      per-lane vehicle counts, lane n at [n*CNT_W +: CNT_W]
//   sensor_fault   sticky per-lane "s5 active while s1 inactive" flag
module lane_sensor_conditioner #(
  parameter int DEB_CYCLES  = 4,
  parameter int CONG_CYCLES = 8,
  parameter int CNT_W       = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         raw_s1,
  input  logic [3:0]         raw_s5,
  input  logic               clr,
  output logic               S1_NS1,
  output logic               S1_NS2,
  output logic               S1_EW1,
  output logic               S1_EW2,
  output logic               S5_NS1,
  output logic               S5_NS2,
  output logic               S5_EW1,
  output logic               S5_EW2,
  output logic [4*CNT_W-1:0] veh_count,
  output logic [3:0]         sensor_fault
);

  localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int CW = $clog2(CONG_CYCLES + 1);
  localparam logic [DW-1:0] DEB_MAX  = DW'(DEB_CYCLES - 1);
  localparam logic [CW-1:0] CONG_MAX = CW'(CONG_CYCLES);

  // Channel index: 0..3 are the s1 loops, 4..7 the s5 loops.
  logic [7:0]       sync1_q, sync2_q;
  logic [7:0]       deb_q, deb_d;
  logic [DW-1:0]    dcnt_q [8];
  logic [DW-1:0]    dcnt_d [8];

  logic [CW-1:0]    cong_q [4];
  logic [CW-1:0]    cong_d [4];
  logic [3:0]       s5_q, s5_d;
  logic [3:0]       s1_prev_q;
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];
  logic [3:0]       fault_q, fault_d;

  always_comb begin
    for (int ch = 0; ch < 8; ch++) begin
      deb_d[ch]  = deb_q[ch];
      dcnt_d[ch] = '0;
      if (sync2_q[ch] != deb_q[ch]) begin
        if (dcnt_q[ch] == DEB_MAX) begin
          deb_d[ch] = sync2_q[ch];
        end else begin
          dcnt_d[ch] = dcnt_q[ch] + DW'(1);
        end
      end
    end
  end

  always_comb begin
    for (int l = 0; l < 4; l++) begin
      cong_d[l]  = '0;
      s5_d[l]    = 1'b0;
      cnt_d[l]   = cnt_q[l];
      fault_d[l] = fault_q[l];

      if (deb_q[l+4]) begin
        cong_d[l] = (cong_q[l] == CONG_MAX) ? cong_q[l] : cong_q[l] + CW'(1);
      end

      // Gating with the next s1 value as well makes S5 drop no later than
      // S1, so S5 can never be seen high while S1 is low.
      s5_d[l] = deb_q[l+4] && deb_q[l] && deb_d[l] && (cong_d[l] == CONG_MAX);

      if (deb_q[l+4] && !deb_q[l]) begin
        fault_d[l] = 1'b1;
      end

      if (deb_q[l] && !s1_prev_q[l] && (cnt_q[l] != '1)) begin
        cnt_d[l] = cnt_q[l] + CNT_W'(1);
      end

      // clr wins over a same-cycle increment or fault set.
      if (clr) begin
        cnt_d[l]   = '0;
        fault_d[l] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      deb_q     <= '0;
      s5_q      <= '0;
      s1_prev_q <= '0;
      fault_q   <= '0;
      for (int ch = 0; ch < 8; ch++) begin
        dcnt_q[ch] <= '0;
      end
      for (int l = 0; l < 4; l++) begin
        cong_q[l] <= '0;
        cnt_q[l]  <= '0;
      end
    end else begin
      sync1_q   <= {raw_s5, raw_s1};
      sync2_q   <= sync1_q;
      deb_q     <= deb_d;
      s5_q      <= s5_d;
      s1_prev_q <= deb_q[3:0];
      fault_q   <= fault_d;
      for (int ch = 0; ch < 8; ch++) begin
        dcnt_q[ch] <= dcnt_d[ch];
      end
      for (int l = 0; l < 4; l++) begin
        cong_q[l] <= cong_d[l];
        cnt_q[l]  <= cnt_d[l];
      end
    end
  end

  assign S1_NS1 = deb_q[0];
  assign S1_NS2 = deb_q[1];
  assign S1_EW1 = deb_q[2];
  assign S1_EW2 = deb_q[3];
  assign S5_NS1 = s5_q[0];
  assign S5_NS2 = s5_q[1];
  assign S5_EW1 = s5_q[2];
  assign S5_EW2 = s5_q[3];
  assign sensor_fault = fault_q;

  always_comb begin
    veh_count = '0;
    for (int l = 0; l < 4; l++) begin
      veh_count[l*CNT_W +: CNT_W] = cnt_q[l];
    end
  end

endmodule

// File: tb/tb_lane_sensor_conditioner.sv
// tb/tb_lane_sensor_conditioner.sv - scoreboard bench for lane_sensor_conditioner
module tb_lane_sensor_conditioner;

  localparam int SEL_S1  = 0;
  localparam int SEL_S5  = 1;
  localparam int SEL_CNT = 2;
  localparam int SEL_FLT = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  raw_s1, raw_s5;
  logic        clr;
  logic        S1_NS1, S1_NS2, S1_EW1, S1_EW2;
  logic        S5_NS1, S5_NS2, S5_EW1, S5_EW2;
  logic [31:0] veh_count;
  logic [3:0]  sensor_fault;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
    int          sel;
  } exp_t;
  exp_t sb_q[$];

  lane_sensor_conditioner #(.DEB_CYCLES(4), .CONG_CYCLES(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .raw_s1(raw_s1), .raw_s5(raw_s5), .clr(clr),
    .S1_NS1(S1_NS1), .S1_NS2(S1_NS2), .S1_EW1(S1_EW1), .S1_EW2(S1_EW2),
    .S5_NS1(S5_NS1), .S5_NS2(S5_NS2), .S5_EW1(S5_EW1), .S5_EW2(S5_EW2),
    .veh_count(veh_count), .sensor_fault(sensor_fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] obs_sel(input int sel);
    case (sel)
      SEL_S1:  return {28'd0, S1_EW2, S1_EW1, S1_NS2, S1_NS1};
      SEL_S5:  return {28'd0, S5_EW2, S5_EW1, S5_NS2, S5_NS1};
      SEL_CNT: return veh_count;
      default: return {28'd0, sensor_fault};
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expected value is queued when the stimulus is applied, then popped and
  // compared against the selected DUT output once n edges have elapsed.
  task automatic expect_after(input string tag, input int sel, input logic [31:0] exp, input int n);
    exp_t e;
    sb_q.push_back('{tag, exp, sel});
    tick(n);
    if (sb_q.size() == 0) begin
      check("sb_underflow", 32'(sb_q.size()), 32'd1);
    end else begin
      e = sb_q.pop_front();
      check(e.tag, obs_sel(e.sel), e.exp);
    end
  endtask

  task automatic pulse_lane(input int lane, input int n);
    for (int i = 0; i < n; i++) begin
      raw_s1[lane] = 1'b1;
      tick(10);
      raw_s1[lane] = 1'b0;
      tick(10);
    end
  endtask

  task automatic clr_pulse();
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
  endtask

  initial begin
    rst = 1'b1; raw_s1 = '0; raw_s5 = '0; clr = 1'b0;

    // Reset state, checked while rst is still high.
    expect_after("rst_s1",  SEL_S1,  0, 3);
    expect_after("rst_s5",  SEL_S5,  0, 0);
    expect_after("rst_cnt", SEL_CNT, 0, 0);
    expect_after("rst_flt", SEL_FLT, 0, 0);
    rst = 1'b0;
    expect_after("post_rst_s1", SEL_S1, 0, 1);

    // Held raw edge on NS1: edge 6 latency, count one edge later.
    raw_s1 = 4'b0001;
    expect_after("t1_s1_e5",  SEL_S1,  0, 5);
    expect_after("t1_s1_e6",  SEL_S1,  1, 1);
    expect_after("t1_cnt_e6", SEL_CNT, 0, 0);
    expect_after("t1_cnt_e7", SEL_CNT, 1, 1);
    raw_s1 = 4'b0000;
    expect_after("t1_s1_fall", SEL_S1, 0, 8);
    // 3-cycle glitch must be rejected.
    raw_s1 = 4'b0001;
    tick(3);
    raw_s1 = 4'b0000;
    for (int i = 0; i < 8; i++) begin
      expect_after("t1_glitch", SEL_S1, 0, 1);
    end
    expect_after("t1_glitch_cnt", SEL_CNT, 1, 0);

    // clr on the same edge as a lane-0 increment.
    raw_s1 = 4'b0001;
    expect_after("t2_s1", SEL_S1, 1, 6);
    clr = 1'b1;
    expect_after("t2_clr_cnt", SEL_CNT, 0, 1);
    clr = 1'b0;
    expect_after("t2_cnt_hold", SEL_CNT, 0, 3);
    raw_s1 = 4'b0000;
    tick(10);

    // Congestion on EW1, then s1 drops first.
    raw_s1 = 4'b0100;
    tick(8);
    raw_s5 = 4'b0100;
    expect_after("t3_s5_e13",  SEL_S5, 0, 13);
    expect_after("t3_s5_e14",  SEL_S5, 4'b0100, 1);
    expect_after("t3_s5_hold", SEL_S5, 4'b0100, 5);
    raw_s1 = 4'b0000;
    expect_after("t3_s5_e5",   SEL_S5,  4'b0100, 5);
    expect_after("t3_s1_e6",   SEL_S1,  0, 1);
    expect_after("t3_s5_e6",   SEL_S5,  0, 0);
    expect_after("t3_flt_e6",  SEL_FLT, 0, 0);
    expect_after("t3_flt_e7",  SEL_FLT, 4'b0100, 1);
    raw_s5 = 4'b0000;
    tick(8);
    clr_pulse();
    expect_after("t3_clr", SEL_FLT, 0, 0);

    // s5 without s1 on EW2: fault only, sticky until clr.
    raw_s5 = 4'b1000;
    expect_after("t4_flt_e6",   SEL_FLT, 0, 6);
    expect_after("t4_flt_e7",   SEL_FLT, 4'b1000, 1);
    expect_after("t4_s5",       SEL_S5,  0, 20);
    raw_s5 = 4'b0000;
    expect_after("t4_flt_hold", SEL_FLT, 4'b1000, 10);
    clr_pulse();
    expect_after("t4_clr", SEL_FLT, 0, 0);

    // Reset in the middle of activity on NS2 with count 5.
    pulse_lane(1, 4);
    raw_s1 = 4'b0010;
    expect_after("t5_pre_s1",  SEL_S1,  4'b0010, 7);
    expect_after("t5_pre_cnt", SEL_CNT, 32'h0000_0500, 0);
    raw_s1 = 4'b0011;
    raw_s5 = 4'b0010;
    tick(3);
    rst = 1'b1;
    expect_after("t5_rst_s1",  SEL_S1,  0, 1);
    expect_after("t5_rst_s5",  SEL_S5,  0, 0);
    expect_after("t5_rst_cnt", SEL_CNT, 0, 0);
    expect_after("t5_rst_flt", SEL_FLT, 0, 0);
    rst = 1'b0;
    raw_s5 = 4'b0000;
    expect_after("t5_s1_e5", SEL_S1, 0, 5);
    expect_after("t5_s1_e6", SEL_S1, 4'b0011, 1);
    raw_s1 = 4'b0000;
    tick(10);
    clr_pulse();

    // Saturation on NS2.
    pulse_lane(1, 254);
    expect_after("t6_cnt_254", SEL_CNT, 32'h0000_FE00, 0);
    pulse_lane(1, 1);
    expect_after("t6_cnt_255", SEL_CNT, 32'h0000_FF00, 0);
    pulse_lane(1, 45);
    expect_after("t6_cnt_sat", SEL_CNT, 32'h0000_FF00, 0);

    // All lanes at once.
    clr_pulse();
    raw_s1 = 4'hF;
    expect_after("t7_s1",  SEL_S1,  4'hF, 6);
    expect_after("t7_cnt", SEL_CNT, 32'h0101_0101, 1);
    raw_s5 = 4'hF;
    expect_after("t7_s5_e13", SEL_S5, 0, 13);
    expect_after("t7_s5_e14", SEL_S5, 4'hF, 1);
    expect_after("t7_flt",    SEL_FLT, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
